// File: rtl/baud_tick_gen.sv
// Runtime-programmable UART baud tick generator: rx_tick at OSR x baud, tx_tick at baud.
// Optional fractional TX/RX prescaler (average period d + frac/16) when BAUD_FRAC_DIV_EN is defined.
module baud_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int OSR         = 16,
  parameter int DEFAULT_DIV = 54
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_wr,
`ifdef BAUD_FRAC_DIV_EN
  input  logic [3:0]       frac_in,
`endif
  input  logic             rx_resync,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic [DIV_W-1:0] div_active,
  output logic             div_pending
);

  localparam int SUB_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(OSR - 1);

  logic [DIV_W-1:0] rx_cnt;
  logic [DIV_W-1:0] tx_cnt;
  logic [SUB_W-1:0] tx_sub;
  logic [DIV_W-1:0] div_pend;

  logic [DIV_W-1:0] d_m1;
  logic [DIV_W:0]   rx_lim;
  logic [DIV_W:0]   tx_lim;
  logic             rx_wrap;
  logic             tx_wrap;
  logic             tx_bit;
  logic             apply;

`ifdef BAUD_FRAC_DIV_EN
  logic [3:0] frac_pend;
  logic [3:0] frac_active;
  logic [3:0] rx_acc;
  logic [3:0] tx_acc;
  logic       rx_extra;
  logic       tx_extra;
  logic [4:0] rx_sum;
  logic [4:0] tx_sum;
`endif

  // A zero divisor behaves as 1; limits are one bit wider so d-1+extra cannot overflow.
  always_comb begin
    d_m1   = (div_active == '0) ? '0 : div_active - DIV_W'(1);
    rx_lim = {1'b0, d_m1};
    tx_lim = {1'b0, d_m1};
`ifdef BAUD_FRAC_DIV_EN
    rx_lim = {1'b0, d_m1} + {{DIV_W{1'b0}}, rx_extra};
    tx_lim = {1'b0, d_m1} + {{DIV_W{1'b0}}, tx_extra};
    rx_sum = {1'b0, rx_acc} + {1'b0, frac_active};
    tx_sum = {1'b0, tx_acc} + {1'b0, frac_active};
`endif
    rx_wrap = ({1'b0, rx_cnt} >= rx_lim);
    tx_wrap = ({1'b0, tx_cnt} >= tx_lim);
    tx_bit  = enable && tx_wrap && (tx_sub == SUB_MAX);
    apply   = div_pending && (!enable || tx_bit);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt  <= '0;
      rx_tick <= 1'b0;
    end else if (!enable || rx_resync) begin
      rx_cnt  <= '0;
      rx_tick <= 1'b0;
    end else if (rx_wrap) begin
      rx_cnt  <= '0;
      rx_tick <= 1'b1;
    end else begin
      rx_cnt  <= rx_cnt + DIV_W'(1);
      rx_tick <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt  <= '0;
      tx_sub  <= '0;
      tx_tick <= 1'b0;
    end else if (!enable) begin
      tx_cnt  <= '0;
      tx_sub  <= '0;
      tx_tick <= 1'b0;
    end else if (tx_wrap) begin
      tx_cnt  <= '0;
      tx_sub  <= tx_bit ? '0 : tx_sub + SUB_W'(1);
      tx_tick <= tx_bit;
    end else begin
      tx_cnt  <= tx_cnt + DIV_W'(1);
      tx_tick <= 1'b0;
    end
  end

  // A write landing on an apply cycle stays pending; the apply takes the older value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_active  <= DEF_DIV;
      div_pend    <= DEF_DIV;
      div_pending <= 1'b0;
    end else begin
      if (apply) begin
        div_active <= div_pend;
      end
      if (div_wr) begin
        div_pend    <= div_in;
        div_pending <= 1'b1;
      end else if (apply) begin
        div_pending <= 1'b0;
      end
    end
  end

`ifdef BAUD_FRAC_DIV_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frac_pend   <= '0;
      frac_active <= '0;
    end else begin
      if (apply) begin
        frac_active <= frac_pend;
      end
      if (div_wr) begin
        frac_pend <= frac_in;
      end
    end
  end

  // Carry out of the accumulator stretches the following prescaler period by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_acc   <= '0;
      rx_extra <= 1'b0;
    end else if (!enable || rx_resync) begin
      rx_acc   <= '0;
      rx_extra <= 1'b0;
    end else if (rx_wrap) begin
      rx_acc   <= rx_sum[3:0];
      rx_extra <= rx_sum[4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_acc   <= '0;
      tx_extra <= 1'b0;
    end else if (!enable) begin
      tx_acc   <= '0;
      tx_extra <= 1'b0;
    end else if (tx_wrap) begin
      tx_acc   <= tx_sum[3:0];
      tx_extra <= tx_sum[4];
    end
  end
`endif

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed self-checking bench for baud_tick_gen (DIV_W=16, OSR=16, DEFAULT_DIV=54).
// Edge numbers below count rising edges since the most recent enable/reset release.
module tb_baud_tick_gen;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [DIV_W-1:0] div_in = '0;
  logic             div_wr = 1'b0;
  logic             rx_resync = 1'b0;
`ifdef BAUD_FRAC_DIV_EN
  logic [3:0]       frac_in = '0;
`endif
  logic             rx_tick;
  logic             tx_tick;
  logic [DIV_W-1:0] div_active;
  logic             div_pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .DIV_W(DIV_W),
    .OSR(16),
    .DEFAULT_DIV(54)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .div_in(div_in),
    .div_wr(div_wr),
`ifdef BAUD_FRAC_DIV_EN
    .frac_in(frac_in),
`endif
    .rx_resync(rx_resync),
    .rx_tick(rx_tick),
    .tx_tick(tx_tick),
    .div_active(div_active),
    .div_pending(div_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads a divisor and pulses enable low for one edge so it applies and counters restart.
  task automatic restart(input logic [DIV_W-1:0] d);
    div_in = d;
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    enable = 1'b0;
    step();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (rx_tick !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_rx_tick: got %b expected 0", rx_tick); end
    n_cmp++; if (tx_tick !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tx_tick: got %b expected 0", tx_tick); end
    n_cmp++; if (div_active !== 16'd54) begin n_bad++; $display("[TB] FAIL reset_div_active: got %0d expected 54", div_active); end
    n_cmp++; if (div_pending !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_div_pending: got %b expected 0", div_pending); end
  endtask

  task automatic test_default();
    int rx_err = 0;
    int tx_err = 0;
    logic er, et;
    reset = 1'b0;
    enable = 1'b1;
    for (int e = 1; e <= 1800; e++) begin
      step();
      er = (e % 54 == 0);
      et = (e % 864 == 0);
      if (rx_tick !== er) rx_err++;
      if (tx_tick !== et) tx_err++;
    end
    n_cmp++; if (rx_err !== 0) begin n_bad++; $display("[TB] FAIL default_rx_pattern: got %0d bad cycles expected 0", rx_err); end
    n_cmp++; if (tx_err !== 0) begin n_bad++; $display("[TB] FAIL default_tx_pattern: got %0d bad cycles expected 0", tx_err); end
    n_cmp++; if (div_pending !== 1'b0) begin n_bad++; $display("[TB] FAIL default_div_pending: got %b expected 0", div_pending); end
    n_cmp++; if (div_active !== 16'd54) begin n_bad++; $display("[TB] FAIL default_div_active: got %0d expected 54", div_active); end
  endtask

  // Continues from edge 1800; divisor 10 is written at 1801 and applied on the tx_tick at 2592.
  task automatic test_div_update();
    int rx_err = 0;
    int tx_err = 0;
    logic er, et;
    div_in = 16'd10;
    for (int e = 1801; e <= 2922; e++) begin
      div_wr = (e == 1801);
      step();
      if (e == 1801) begin
        n_cmp++; if (div_pending !== 1'b1) begin n_bad++; $display("[TB] FAIL upd_pending_set: got %b expected 1", div_pending); end
      end
      if (e == 2591) begin
        n_cmp++; if (div_active !== 16'd54) begin n_bad++; $display("[TB] FAIL upd_active_before: got %0d expected 54", div_active); end
      end
      if (e == 2592) begin
        n_cmp++; if (div_active !== 16'd10) begin n_bad++; $display("[TB] FAIL upd_active_after: got %0d expected 10", div_active); end
        n_cmp++; if (div_pending !== 1'b0) begin n_bad++; $display("[TB] FAIL upd_pending_clr: got %b expected 0", div_pending); end
      end
      er = (e <= 2592) ? (e % 54 == 0) : ((e - 2592) % 10 == 0);
      et = (e == 2592) || ((e > 2592) && ((e - 2592) % 160 == 0));
      if (rx_tick !== er) rx_err++;
      if (tx_tick !== et) tx_err++;
    end
    div_wr = 1'b0;
    n_cmp++; if (rx_err !== 0) begin n_bad++; $display("[TB] FAIL upd_rx_pattern: got %0d bad cycles expected 0", rx_err); end
    n_cmp++; if (tx_err !== 0) begin n_bad++; $display("[TB] FAIL upd_tx_pattern: got %0d bad cycles expected 0", tx_err); end
  endtask

  // Resync at 824 leaves rx_cnt=40 when divisor 8 applies at 864, so RX must wrap at 865.
  task automatic test_shrink();
    int rx_err = 0;
    int tx_err = 0;
    logic er, et;
    restart(16'd54);
    div_in = 16'd8;
    for (int e = 1; e <= 1100; e++) begin
      div_wr = (e == 100);
      rx_resync = (e == 824);
      step();
      if (e == 864) begin
        n_cmp++; if (div_active !== 16'd8) begin n_bad++; $display("[TB] FAIL shrink_active: got %0d expected 8", div_active); end
      end
      if (e < 824) er = (e % 54 == 0);
      else if (e < 865) er = 1'b0;
      else er = ((e - 865) % 8 == 0);
      et = (e == 864) || ((e > 864) && ((e - 864) % 128 == 0));
      if (rx_tick !== er) rx_err++;
      if (tx_tick !== et) tx_err++;
    end
    div_wr = 1'b0;
    rx_resync = 1'b0;
    n_cmp++; if (rx_err !== 0) begin n_bad++; $display("[TB] FAIL shrink_rx_pattern: got %0d bad cycles expected 0", rx_err); end
    n_cmp++; if (tx_err !== 0) begin n_bad++; $display("[TB] FAIL shrink_tx_pattern: got %0d bad cycles expected 0", tx_err); end
  endtask

  // Resync at 74 moves the tick from 108 to 128; resync at 182 collides with a wrap and wins.
  task automatic test_resync();
    int rx_err = 0;
    int tx_err = 0;
    logic er, et;
    restart(16'd54);
    for (int e = 1; e <= 900; e++) begin
      rx_resync = (e == 74) || (e == 182);
      step();
      if (e < 74) er = (e % 54 == 0);
      else if (e == 74 || e == 182) er = 1'b0;
      else if (e < 182) er = ((e - 74) % 54 == 0);
      else er = ((e - 182) % 54 == 0);
      et = (e % 864 == 0);
      if (e == 108) begin
        n_cmp++; if (rx_tick !== 1'b0) begin n_bad++; $display("[TB] FAIL resync_old_slot: got %b expected 0", rx_tick); end
      end
      if (e == 182) begin
        n_cmp++; if (rx_tick !== 1'b0) begin n_bad++; $display("[TB] FAIL resync_collide: got %b expected 0", rx_tick); end
      end
      if (rx_tick !== er) rx_err++;
      if (tx_tick !== et) tx_err++;
    end
    rx_resync = 1'b0;
    n_cmp++; if (rx_err !== 0) begin n_bad++; $display("[TB] FAIL resync_rx_pattern: got %0d bad cycles expected 0", rx_err); end
    n_cmp++; if (tx_err !== 0) begin n_bad++; $display("[TB] FAIL resync_tx_pattern: got %0d bad cycles expected 0", tx_err); end
  endtask

  task automatic test_enable_low();
    int tick_err = 0;
    int rx_err = 0;
    int tx_err = 0;
    div_in = 16'd0;
    div_wr = 1'b1;
    step();
    n_cmp++; if (div_pending !== 1'b1) begin n_bad++; $display("[TB] FAIL en_pending_set: got %b expected 1", div_pending); end
    n_cmp++; if (div_active !== 16'd54) begin n_bad++; $display("[TB] FAIL en_active_held: got %0d expected 54", div_active); end
    enable = 1'b0;
    div_in = 16'd5;
    step();
    n_cmp++; if (div_active !== 16'd0) begin n_bad++; $display("[TB] FAIL en_apply_old: got %0d expected 0", div_active); end
    n_cmp++; if (div_pending !== 1'b1) begin n_bad++; $display("[TB] FAIL en_new_pending: got %b expected 1", div_pending); end
    n_cmp++; if ({rx_tick, tx_tick} !== 2'b00) begin n_bad++; $display("[TB] FAIL en_ticks_stop: got %b expected 00", {rx_tick, tx_tick}); end
    div_in = 16'd0;
    step();
    n_cmp++; if (div_active !== 16'd5) begin n_bad++; $display("[TB] FAIL en_apply_5: got %0d expected 5", div_active); end
    div_wr = 1'b0;
    step();
    n_cmp++; if (div_active !== 16'd0) begin n_bad++; $display("[TB] FAIL en_apply_0: got %0d expected 0", div_active); end
    n_cmp++; if (div_pending !== 1'b0) begin n_bad++; $display("[TB] FAIL en_pending_clr: got %b expected 0", div_pending); end
    for (int i = 0; i < 2; i++) begin
      step();
      if ({rx_tick, tx_tick} !== 2'b00) tick_err++;
    end
    n_cmp++; if (tick_err !== 0) begin n_bad++; $display("[TB] FAIL en_low_ticks: got %0d bad cycles expected 0", tick_err); end
    enable = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (rx_tick !== 1'b1) rx_err++;
      if (tx_tick !== (e % 16 == 0)) tx_err++;
    end
    n_cmp++; if (rx_err !== 0) begin n_bad++; $display("[TB] FAIL div0_rx_pattern: got %0d bad cycles expected 0", rx_err); end
    n_cmp++; if (tx_err !== 0) begin n_bad++; $display("[TB] FAIL div0_tx_pattern: got %0d bad cycles expected 0", tx_err); end
  endtask

  task automatic test_reset_mid();
    int rx_err = 0;
    int tx_err = 0;
    div_in = 16'd20;
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    n_cmp++; if (div_pending !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid_pending: got %b expected 1", div_pending); end
    step();
    n_cmp++; if (rx_tick !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid_running: got %b expected 1", rx_tick); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({rx_tick, tx_tick} !== 2'b00) begin n_bad++; $display("[TB] FAIL rst_mid_ticks: got %b expected 00", {rx_tick, tx_tick}); end
    n_cmp++; if (div_active !== 16'd54) begin n_bad++; $display("[TB] FAIL rst_mid_active: got %0d expected 54", div_active); end
    n_cmp++; if (div_pending !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_pending_lost: got %b expected 0", div_pending); end
    step();
    reset = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      step();
      if (rx_tick !== (e == 54)) rx_err++;
      if (tx_tick !== 1'b0) tx_err++;
    end
    n_cmp++; if (rx_err !== 0) begin n_bad++; $display("[TB] FAIL rst_mid_rx_restart: got %0d bad cycles expected 0", rx_err); end
    n_cmp++; if (tx_err !== 0) begin n_bad++; $display("[TB] FAIL rst_mid_tx_restart: got %0d bad cycles expected 0", tx_err); end
  endtask

`ifdef BAUD_FRAC_DIV_EN
  // d=10, frac=8: periods 10,10,11,10,11,... so 16 prescaler periods end at edge 167.
  task automatic test_frac();
    int rx_err = 0;
    int tx_err = 0;
    logic er;
    frac_in = 4'd8;
    restart(16'd10);
    frac_in = 4'd0;
    for (int e = 1; e <= 170; e++) begin
      step();
      er = (e inside {10, 20, 31, 41, 52, 62, 73, 83, 94, 104, 115, 125, 136, 146, 157, 167});
      if (rx_tick !== er) rx_err++;
      if (tx_tick !== (e == 167)) tx_err++;
    end
    n_cmp++; if (rx_err !== 0) begin n_bad++; $display("[TB] FAIL frac_rx_pattern: got %0d bad cycles expected 0", rx_err); end
    n_cmp++; if (tx_err !== 0) begin n_bad++; $display("[TB] FAIL frac_tx_pattern: got %0d bad cycles expected 0", tx_err); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] baud_tick_gen directed tests start");
    test_reset();
    test_default();
    test_div_update();
    test_shrink();
    test_resync();
    test_enable_low();
    test_reset_mid();
`ifdef BAUD_FRAC_DIV_EN
    test_frac();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
